// File: rtl/fxp_round_sat_pipe_if.sv
// Stream bundle for fxp_round_sat_pipe: upstream sample beats in, rounded integer beats out.
// The master side is the surrounding datapath; the slave side is the converter itself.
interface fxp_round_sat_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int LANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*IN_W-1:0]    in_data;
    logic [1:0]               in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic [LANES-1:0]         out_sat;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fxp_round_sat_pipe.sv
// Multi-lane signed fixed-point to integer converter: S1 rounds, S2 saturates; 2-cycle valid/ready pipe.
// Build macro SYMMETRIC_SAT_EN narrows the negative limit to -(2^(OUT_W-1)-1).
module fxp_round_sat_pipe #(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fxp_round_sat_pipe_if.slave  bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     sat_count
);
    localparam int RW    = IN_W + 1 - FRAC_W;
    localparam int PW    = $clog2(LANES + 1);
    localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
`ifdef SYMMETRIC_SAT_EN
    localparam int MIN_I = -MAX_I;
`else
    localparam int MIN_I = -MAX_I - 1;
`endif
    localparam logic signed [RW-1:0]   MAX_R   = RW'(MAX_I);
    localparam logic signed [RW-1:0]   MIN_R   = RW'(MIN_I);
    localparam logic signed [IN_W:0]   HALF    = (IN_W+1)'(1 << (FRAC_W - 1));
    localparam logic signed [IN_W:0]   HALF_M1 = (IN_W+1)'((1 << (FRAC_W - 1)) - 1);
    localparam logic [CNT_W+PW-1:0]    CNT_MAX = (CNT_W+PW)'({CNT_W{1'b1}});

    logic                          en;
    logic                          s1_valid_reg;
    logic [LANES-1:0][RW-1:0]      s1_r_reg;
    logic [LANES-1:0][RW-1:0]      round_r;
    logic [LANES-1:0][OUT_W-1:0]   sat_data;
    logic [LANES-1:0]              sat_flag;
    logic [LANES-1:0]              unused_frac;
    logic                          out_valid_reg;
    logic [LANES-1:0][OUT_W-1:0]   out_data_reg;
    logic [LANES-1:0]              out_sat_reg;
    logic [CNT_W-1:0]              sat_count_reg;
    logic [CNT_W-1:0]              sat_count_next;
    logic [PW-1:0]                 sat_pop;
    logic [CNT_W+PW-1:0]           cnt_sum;

    // Whole pipe advances together; the output register is the only place a stall originates.
    assign en           = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sat   = out_sat_reg;
    assign sat_count     = sat_count_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [IN_W:0]  x_ext;
        logic signed [IN_W:0]  odd;
        logic signed [IN_W:0]  sum;
        logic signed [RW-1:0]  r;
        logic                  hi;
        logic                  lo;

        assign x_ext = {bus.in_data[gi*IN_W + IN_W - 1], bus.in_data[gi*IN_W +: IN_W]};
        assign odd   = {{IN_W{1'b0}}, x_ext[FRAC_W]};

        // One extra bit of headroom means the bias add can never overflow.
        assign sum = (bus.in_mode == 2'b00) ? x_ext :
                     (bus.in_mode == 2'b01) ? x_ext + HALF :
                     (bus.in_mode == 2'b10) ? (x_ext[IN_W] ? x_ext + HALF_M1 : x_ext + HALF) :
                                              x_ext + HALF_M1 + odd;

        assign round_r[gi]     = sum[IN_W:FRAC_W];
        assign unused_frac[gi] = ^sum[FRAC_W-1:0];

        assign r  = s1_r_reg[gi];
        assign hi = r > MAX_R;
        assign lo = r < MIN_R;
        assign sat_data[gi] = hi ? MAX_R[OUT_W-1:0] : (lo ? MIN_R[OUT_W-1:0] : r[OUT_W-1:0]);
        assign sat_flag[gi] = hi | lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_r_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= '0;
        end else if (en) begin
            s1_valid_reg  <= bus.in_valid;
            out_valid_reg <= s1_valid_reg;
            if (bus.in_valid) begin
                s1_r_reg <= round_r;
            end
            if (s1_valid_reg) begin
                out_data_reg <= sat_data;
                out_sat_reg  <= sat_flag;
            end
        end
    end

    // Counter clamps at all-ones; a clear wins over an increment in the same cycle.
    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_pop = sat_pop + PW'(out_sat_reg[i]);
        end
        cnt_sum        = (CNT_W+PW)'(sat_count_reg) + (CNT_W+PW)'(sat_pop);
        sat_count_next = sat_count_reg;
        if (cnt_clr) begin
            sat_count_next = '0;
        end else if (out_valid_reg && bus.out_ready) begin
            sat_count_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_reg <= '0;
        end else begin
            sat_count_reg <= sat_count_next;
        end
    end
endmodule
